// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: sigma constants,
// round counts per word width and the expander FSM states.
package sha2_pkg;

    localparam int IDX_W = 7;
    localparam int WIN   = 16;

    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_S  = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_S  = 10;

    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_S  = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_S  = 6;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    function automatic int rounds_of(input int w);
        return (w == 64) ? ROUNDS_512 : ROUNDS_256;
    endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// Block input stream and schedule output stream of the expander.
interface msg_schedule_if
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [IDX_W-1:0]      w_index;
    logic                  w_last;
    logic                  busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  w_ready,
        output in_ready,
        output w_valid,
        output w_data,
        output w_index,
        output w_last,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output w_ready,
        input  in_ready,
        input  w_valid,
        input  w_data,
        input  w_index,
        input  w_last,
        input  busy
    );

endinterface

// File: rtl/small_sigma.sv
// SHA-2 small sigma: ROTR_R1(x) ^ ROTR_R2(x) ^ SHR_S(x).
module small_sigma #(
    parameter int DATA_WIDTH = 32,
    parameter int R1         = 7,
    parameter int R2         = 18,
    parameter int S          = 3
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] rot1;
    logic [DATA_WIDTH-1:0] rot2;
    logic [DATA_WIDTH-1:0] shr;

    assign rot1 = (x >> R1) | (x << (DATA_WIDTH - R1));
    assign rot2 = (x >> R2) | (x << (DATA_WIDTH - R2));
    assign shr  = x >> S;
    assign y    = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message-schedule expander: loads 16 words, then streams
// W_0..W_{ROUNDS-1} from a 16-word sliding window.
module msg_schedule
    import sha2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    msg_schedule_if.slave    bus
);

    localparam int ROUNDS = rounds_of(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);

    localparam bit WIDE  = (DATA_WIDTH == 64);
    localparam int S0_R1 = WIDE ? S512_S0_R1 : S256_S0_R1;
    localparam int S0_R2 = WIDE ? S512_S0_R2 : S256_S0_R2;
    localparam int S0_S  = WIDE ? S512_S0_S  : S256_S0_S;
    localparam int S1_R1 = WIDE ? S512_S1_R1 : S256_S1_R1;
    localparam int S1_R2 = WIDE ? S512_S1_R2 : S256_S1_R2;
    localparam int S1_S  = WIDE ? S512_S1_S  : S256_S1_S;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("msg_schedule: DATA_WIDTH must be 32 or 64");
    end

    state_e                state_q, state_d;
    logic [3:0]            lcnt_q, lcnt_d;
    logic [IDX_W-1:0]      t_q, t_d;
    logic [DATA_WIDTH-1:0] win_q [WIN];
    logic [DATA_WIDTH-1:0] win_d [WIN];

    logic [DATA_WIDTH-1:0] sig0;
    logic [DATA_WIDTH-1:0] sig1;
    logic [DATA_WIDTH-1:0] w_new;
    logic                  in_fire;
    logic                  w_fire;

    small_sigma #(
        .DATA_WIDTH (DATA_WIDTH),
        .R1         (S0_R1),
        .R2         (S0_R2),
        .S          (S0_S)
    ) u_sigma0 (
        .x (win_q[1]),
        .y (sig0)
    );

    small_sigma #(
        .DATA_WIDTH (DATA_WIDTH),
        .R1         (S1_R1),
        .R2         (S1_R2),
        .S          (S1_S)
    ) u_sigma1 (
        .x (win_q[14]),
        .y (sig1)
    );

    // Carry out of the top bit is dropped: modulo 2^DATA_WIDTH.
    assign w_new   = sig1 + win_q[9] + sig0 + win_q[0];
    assign in_fire = bus.in_valid && (state_q == LOAD);
    assign w_fire  = bus.w_ready && (state_q == EXPAND);

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        t_d     = t_q;
        win_d   = win_q;
        if (in_fire) begin
            for (int i = 0; i < WIN - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WIN-1] = bus.in_data;
            if (lcnt_q == 4'd15) begin
                lcnt_d  = 4'd0;
                t_d     = '0;
                state_d = EXPAND;
            end else begin
                lcnt_d = lcnt_q + 4'd1;
            end
        end
        if (w_fire) begin
            for (int i = 0; i < WIN - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WIN-1] = w_new;
            if (t_q == LAST_T) begin
                t_d     = '0;
                state_d = LOAD;
            end else begin
                t_d = t_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            lcnt_q  <= 4'd0;
            t_q     <= '0;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            t_q     <= t_d;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // All outputs decode from flops only; no input reaches them.
    assign bus.in_ready = (state_q == LOAD);
    assign bus.w_valid  = (state_q == EXPAND);
    assign bus.busy     = (state_q == EXPAND);
    assign bus.w_data   = (state_q == EXPAND) ? win_q[0] : '0;
    assign bus.w_index  = t_q;
    assign bus.w_last   = (state_q == EXPAND) && (t_q == LAST_T);

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule at both word widths.
module tb_msg_schedule;
    import sha2_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    msg_schedule_if #(.DATA_WIDTH(32)) b32 ();
    msg_schedule_if #(.DATA_WIDTH(64)) b64 ();

    msg_schedule #(.DATA_WIDTH(32)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    msg_schedule #(.DATA_WIDTH(64)) u64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    typedef struct {
        bit          wide;
        int          idx;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_got;
    logic [63:0] blk     [16];
    logic [63:0] model   [80];
    logic [63:0] cap     [80];
    logic [63:0] ref_cap [80];

    logic        s_v, s_rdy, s_last, s_busy;
    logic [63:0] s_data;
    logic [6:0]  s_idx;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mask(input bit wide);
        return wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r,
                                         input bit wide);
        logic [127:0] d;
        if (wide) begin
            d = {x, x} >> r;
            return d[63:0];
        end
        d = {64'b0, x[31:0], x[31:0]} >> r;
        return {32'b0, d[31:0]};
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input bit wide);
        if (wide) return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
        return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ ((x & mask(0)) >> 3);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input bit wide);
        if (wide) return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
        return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ ((x & mask(0)) >> 10);
    endfunction

    task automatic build_model(input bit wide);
        int r = wide ? 80 : 64;
        for (int t = 0; t < 80; t++) model[t] = '0;
        for (int t = 0; t < 16; t++) model[t] = blk[t] & mask(wide);
        for (int t = 16; t < r; t++) begin
            model[t] = (ssig1(model[t-2], wide) + model[t-7]
                      + ssig0(model[t-15], wide) + model[t-16]) & mask(wide);
        end
    endtask

    task automatic rand_blk(input bit wide);
        for (int i = 0; i < 16; i++) begin
            blk[i] = wide ? {$urandom, $urandom} : {32'b0, $urandom};
        end
    endtask

    task automatic sample(input bit wide);
        if (wide) begin
            s_v = b64.w_valid;   s_rdy  = b64.in_ready;
            s_last = b64.w_last; s_busy = b64.busy;
            s_data = b64.w_data; s_idx  = b64.w_index;
        end else begin
            s_v = b32.w_valid;   s_rdy  = b32.in_ready;
            s_last = b32.w_last; s_busy = b32.busy;
            s_data = {32'b0, b32.w_data}; s_idx = b32.w_index;
        end
    endtask

    task automatic set_in(input bit wide, input logic v, input logic [63:0] d);
        if (wide) begin
            b64.in_valid = v;
            b64.in_data  = d;
        end else begin
            b32.in_valid = v;
            b32.in_data  = d[31:0];
        end
    endtask

    task automatic set_wr(input bit wide, input logic r);
        if (wide) b64.w_ready = r;
        else      b32.w_ready = r;
    endtask

    task automatic load(input bit wide, input int nwords, input bit gaps);
        int i = 0;
        set_wr(wide, 1'b0);
        while (i < nwords) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                set_in(wide, 1'b0, {$urandom, $urandom});
            end else begin
                sample(wide);
                chk("in_ready_load", s_rdy, 1);
                set_in(wide, 1'b1, blk[i]);
                i++;
            end
        end
        @(negedge clk);
        set_in(wide, 1'b0, '0);
        if (nwords == 16) begin
            sample(wide);
            chk("first_valid", s_v, 1);
            chk("first_index", s_idx, 0);
            chk("busy_expand", s_busy, 1);
            chk("in_ready_expand", s_rdy, 0);
        end
    endtask

    // mode 0: always ready; 1: random ready plus 5-cycle stall at t=20;
    // 2: always ready with in_valid noise. stop_at>=0 returns mid-block.
    task automatic drain(input bit wide, input int mode, input int stop_at);
        int          r_cnt = wide ? 80 : 64;
        bit          done = 0, hold = 0, stalled = 0;
        int          stall = 0;
        logic [63:0] pd;
        logic [6:0]  pi;
        logic        r;
        n_got = 0;
        for (int t = 0; t < 80; t++) cap[t] = 'x;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            sample(wide);
            if (hold) begin
                chk("hold_valid", s_v, 1);
                chk("hold_data", s_data, pd);
                chk("hold_index", s_idx, pi);
            end
            if (stop_at >= 0 && s_v && s_idx == 7'(stop_at)) begin
                set_wr(wide, 1'b0);
                done = 1;
            end else begin
                r = 1'b1;
                if (mode == 1) begin
                    if (s_v && s_idx == 7'd20 && !stalled) begin
                        stalled = 1;
                        stall   = 5;
                    end
                    if (stall > 0) begin
                        r = 1'b0;
                        stall--;
                    end else begin
                        r = 1'($urandom_range(0, 1));
                    end
                end
                set_wr(wide, r);
                if (mode == 2) begin
                    chk("in_ready_noise", s_rdy, 0);
                    set_in(wide, !s_last, {$urandom, $urandom});
                end
                if (s_v && r) begin
                    chk("w_index", s_idx, n_got);
                    chk("w_last", s_last, (n_got == r_cnt - 1));
                    cap[s_idx] = s_data;
                    n_got++;
                    if (s_last) done = 1;
                end
                hold = s_v && !r;
                pd   = s_data;
                pi   = s_idx;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words expected %0d", n_got, r_cnt);
        end
        if (stop_at < 0) begin
            @(negedge clk);
            sample(wide);
            chk("in_ready_after", s_rdy, 1);
            chk("w_valid_after", s_v, 0);
            set_wr(wide, 1'b0);
            set_in(wide, 1'b0, '0);
        end
    endtask

    task automatic cmp_all(input bit wide, input string nm);
        int r_cnt = wide ? 80 : 64;
        chk({nm, "_count"}, n_got, r_cnt);
        for (int t = 0; t < r_cnt; t++) begin
            chk($sformatf("%s_w%0d", nm, t), cap[t], model[t]);
        end
    endtask

    task automatic check_idle(input string nm);
        sample(0);
        chk({nm, "_in_ready"}, s_rdy, 1);
        chk({nm, "_w_valid"}, s_v, 0);
        chk({nm, "_w_data"}, s_data, 0);
        chk({nm, "_w_index"}, s_idx, 0);
        chk({nm, "_w_last"}, s_last, 0);
        chk({nm, "_busy"}, s_busy, 0);
    endtask

    initial begin
        vecs[0] = '{0, 0,  64'h6162_6380};
        vecs[1] = '{0, 1,  64'h0};
        vecs[2] = '{0, 15, 64'h18};
        vecs[3] = '{0, 16, 64'h6162_6380};
        vecs[4] = '{0, 17, 64'h000F_0000};
        vecs[5] = '{0, 18, 64'h7DA8_6405};
        vecs[6] = '{1, 0,  64'h1};
        vecs[7] = '{1, 16, 64'h1};
        vecs[8] = '{1, 17, 64'h0};
        vecs[9] = '{1, 18, 64'h0000_2000_0000_0008};

        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        set_wr(0, 1'b0);
        set_wr(1, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        sample(1);
        chk("reset_in_ready64", s_rdy, 1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 64'h6162_6380;
        blk[15] = 64'h18;
        build_model(0);
        load(0, 16, 0);
        drain(0, 0, -1);
        cmp_all(0, "abc");
        for (int t = 0; t < 80; t++) ref_cap[t] = cap[t];
        for (int k = 0; k < 10; k++) begin
            if (!vecs[k].wide)
                chk($sformatf("abc_vec_w%0d", vecs[k].idx),
                    cap[vecs[k].idx], vecs[k].exp);
        end

        load(0, 16, 1);
        drain(0, 1, -1);
        cmp_all(0, "abc_stall");
        for (int t = 0; t < 64; t++) begin
            chk($sformatf("stall_vs_free_w%0d", t), cap[t], ref_cap[t]);
        end

        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h1;
        build_model(1);
        load(1, 16, 0);
        drain(1, 0, -1);
        cmp_all(1, "one64");
        for (int k = 0; k < 10; k++) begin
            if (vecs[k].wide)
                chk($sformatf("one64_vec_w%0d", vecs[k].idx),
                    cap[vecs[k].idx], vecs[k].exp);
        end

        rand_blk(1);
        build_model(1);
        load(1, 16, 1);
        drain(1, 1, -1);
        cmp_all(1, "rand64_stall");

        rand_blk(0);
        load(0, 16, 0);
        drain(0, 0, 30);
        #2 rst = 1'b1;
        #1 check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        rand_blk(0);
        build_model(0);
        load(0, 16, 0);
        drain(0, 0, -1);
        cmp_all(0, "after_rst");

        rand_blk(0);
        build_model(0);
        load(0, 16, 0);
        drain(0, 2, -1);
        cmp_all(0, "noise");
        rand_blk(0);
        build_model(0);
        load(0, 16, 0);
        drain(0, 0, -1);
        cmp_all(0, "b2b");

        rand_blk(0);
        load(0, 7, 0);
        rst = 1'b1;
        #1 check_idle("part_rst");
        @(negedge clk);
        rst = 1'b0;
        rand_blk(0);
        build_model(0);
        load(0, 16, 1);
        drain(0, 1, -1);
        cmp_all(0, "partial");
        chk("partial_first", cap[0], blk[0] & mask(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
